multi_accumulator: RTL
======================

MULTI_ACCUMULATOR -- requirements
Module: multi_accumulator

Interface
REQ-001 Parameter WIDTH SHALL have default 8 and set the datapath width, legal range 2 or more.
REQ-002 Parameter NREGS SHALL have default 4 and set the operand register count, power of 2, 2 or more; SELW = log2(NREGS).
REQ-003 Parameter SATURATE SHALL have default 0; when 1, it selects clamping arithmetic instead of wrap-around arithmetic.
REQ-004 The module SHALL have the following ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
- cmd_op  in  3  opcode.
- cmd_sel  in  SELW  operand register index.
- cmd_data  in  WIDTH  immediate value, or iteration count for MAC.
- acc_out  out  WIDTH  accumulator A, driven directly from its register.
- cf  out  1  carry/borrow flag.
- zf  out  1  zero flag; high when A equals 0 after the last flag-updating op.
- done  out  1  one-cycle pulse marking command completion.

Function
REQ-005 The opcodes SHALL be: 0 NOP; 1 LDA (A = data); 2 LDR (R[sel] = data); 3 ADD (A = A + R[sel]); 4 SUB (A = A - R[sel]); 5 MAC (A = A + R[sel], repeated data times); 6 CLR; 7 reserved, executed as NOP.
REQ-006 The FSM SHALL have exactly two states, IDLE and LOOP; cmd_ready SHALL be 1 in IDLE and 0 in LOOP.
REQ-007 NOP, LDA, LDR, ADD, SUB and CLR SHALL update their state on the acceptance edge, stay in IDLE, and raise done in the following cycle, so back-to-back acceptance is possible every cycle.
REQ-008 MAC with data = N > 0 SHALL, on acceptance:
- snapshot R[sel] into an operand register;
- load the counter with N;
- enter LOOP.
REQ-009 Each LOOP edge SHALL add the operand to A and decrement the counter; on the edge that performs the Nth add the FSM SHALL return to IDLE, and done SHALL be high in the next cycle, giving N+1 cycles from acceptance to the done cycle.
REQ-010 MAC with data = 0 SHALL leave A and the flags unchanged, stay in IDLE, and pulse done in the next cycle.
REQ-011 Wrap mode (SATURATE = 0) SHALL compute results modulo 2^WIDTH.
REQ-012 ADD/MAC SHALL set cf on carry-out, and MAC cf SHALL be sticky across iterations, cleared at MAC acceptance.
REQ-013 SUB SHALL set cf when A < R[sel] (borrow).
REQ-014 Saturate mode (SATURATE = 1) SHALL clamp ADD/MAC results to all-ones on carry and SUB results to 0 on borrow, with cf reported as in wrap mode.
REQ-015 LDA SHALL clear cf and update zf.
REQ-016 LDR SHALL leave A, cf and zf unchanged.
REQ-017 CLR SHALL set A = 0, cf = 0, zf = 1.
REQ-018 NOP SHALL change nothing except pulse done.
REQ-019 zf SHALL be updated on every A write and SHALL reflect the final A value.
REQ-020 A command presented while cmd_ready is 0 SHALL be ignored; the sender holds cmd_valid and the command fields stable until acceptance.
REQ-021 During MAC, the operand register SHALL be isolated from R[sel]; LDR cannot reach R[sel] during MAC because cmd_ready is low.

Reset
REQ-022 While rst_n is low, all of the following SHALL hold:
- A = 0, all R = 0;
- cf = 0, zf = 1, done = 0;
- counter = 0, state = IDLE;
- cmd_ready = 0.
REQ-023 cmd_ready SHALL rise in the first cycle after rst_n is released.
REQ-024 Reset asserted mid-MAC SHALL abort the operation without any done pulse.

Structure
REQ-025 A shared package accum_pkg SHALL hold the opcode enum, the FSM state enum and the SELW helper.
REQ-026 The register file SHALL be one sub-module, accum_regfile, with NREGS x WIDTH entries, one write port, one asynchronous read port, and asynchronous reset to 0.

Verification (WIDTH = 8, NREGS = 4)
REQ-027 Scenario 1: LDA 0xF0, LDR R1 = 0x20, ADD sel 1 -> acc_out 0x10, cf 1, zf 0, one done pulse per command.
REQ-028 Scenario 2: LDA 0x05, LDR R2 = 0x05, SUB sel 2 -> acc_out 0x00, zf 1, cf 0; then LDR R2 = 0x06, SUB sel 2 -> acc_out 0xFA, cf 1.
REQ-029 Scenario 3: CLR, LDR R0 = 3, MAC sel 0 data 5 -> cmd_ready low for 5 cycles, acc_out 0x0F, done 6 cycles after acceptance; then MAC data 0 -> acc_out still 0x0F, done next cycle.
REQ-030 Scenario 4 (SATURATE = 1): LDA 0xFE, LDR R3 = 0x04, ADD sel 3 -> acc_out 0xFF, cf 1; LDA 0x02, SUB sel 3 -> acc_out 0x00, cf 1, zf 1.
REQ-031 Scenario 5: LDA 0x33 held on cmd_valid during a MAC -> accepted on the first cycle cmd_ready is 1, after the MAC done pulse; acc_out becomes 0x33 with no lost or duplicated command.
REQ-032 Scenario 6: rst_n pulsed low on the third LOOP cycle of a MAC data 10 -> acc_out 0, zf 1, no done pulse, cmd_ready 1 one cycle after release.

Source files
------------

// File: rtl/accum_pkg.sv
// Purpose: shared opcode/state enums and select-width helper for the multi-accumulator.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package accum_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDA = 3'd1,
        OP_LDR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_MAC = 3'd5,
        OP_CLR = 3'd6,
        OP_RSV = 3'd7
    } op_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOOP = 1'b1
    } state_t;

    // Index width for an operand register file of n entries (n a power of two, n >= 2).
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/accum_regfile.sv
// Purpose: NREGS x WIDTH operand register file, one write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; a write is taken on every edge where wr_vld is high.
//
// Ports: clk/rst_n clock and async active-low reset (clears every entry);
//        wr_vld/wr_sel/wr_dat write strobe, index and data; rd_sel/rd_dat read index and data.
module accum_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int SELW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_vld,
    input  logic [SELW-1:0]   wr_sel,
    input  logic [WIDTH-1:0]  wr_dat,
    input  logic [SELW-1:0]   rd_sel,
    output logic [WIDTH-1:0]  rd_dat
);

    logic [WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_vld) begin
            regs_q[wr_sel] <= wr_dat;
        end
    end

    assign rd_dat = regs_q[rd_sel];

endmodule

// File: rtl/multi_accumulator.sv
// Purpose: accumulator with operand register file, add/sub/multi-cycle MAC, carry and zero flags.
// Latency: done one cycle after acceptance; MAC with count N > 0 gives done N+1 cycles after acceptance.
// Backpressure: cmd_ready low in reset and for the whole MAC loop; held commands wait for ready.
//
// Ports: clk/rst_n clock and async active-low reset; cmd_valid/cmd_ready command handshake;
//        cmd_op/cmd_sel/cmd_data opcode, register index, immediate or MAC count;
//        acc_out accumulator register; cf carry/borrow flag; zf zero flag; done completion pulse.
module multi_accumulator
    import accum_pkg::*;
#(
    parameter int  WIDTH    = 8,
    parameter int  NREGS    = 4,
    parameter int  SATURATE = 0,
    localparam int SELW     = sel_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [SELW-1:0]   cmd_sel,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic [WIDTH-1:0]  acc_out,
    output logic              cf,
    output logic              zf,
    output logic              done
);

    op_t               op;
    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              loop_last;
    logic              live_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  cnt_q;
    logic              cf_q;
    logic              zf_q;
    logic              done_q;
    logic [WIDTH-1:0]  rd_dat;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH:0]    sum_w;
    logic [WIDTH:0]    dif_w;
    logic [WIDTH-1:0]  add_res;
    logic [WIDTH-1:0]  sub_res;

    assign op = op_t'(cmd_op);

    accum_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .SELW  (SELW)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (accept && (op == OP_LDR)),
        .wr_sel (cmd_sel),
        .wr_dat (cmd_data),
        .rd_sel (cmd_sel),
        .rd_dat (rd_dat)
    );

    // One adder/subtractor pair serves both single ops and the MAC loop; in LOOP the
    // snapshot register feeds it so the register file is out of the path.
    assign operand = (state_q == ST_LOOP) ? opnd_q : rd_dat;
    assign sum_w   = {1'b0, acc_q} + {1'b0, operand};
    assign dif_w   = {1'b0, acc_q} - {1'b0, operand};
    assign add_res = ((SATURATE != 0) && sum_w[WIDTH]) ? '1 : sum_w[WIDTH-1:0];
    assign sub_res = ((SATURATE != 0) && dif_w[WIDTH]) ? '0 : dif_w[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        loop_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // live_q holds ready low until the first edge after reset release.
                cmd_ready = live_q;
                accept    = cmd_valid && live_q;
                if (accept && (op == OP_MAC) && (cmd_data != '0)) begin
                    state_d = ST_LOOP;
                end
            end
            ST_LOOP: begin
                if (cnt_q == WIDTH'(1)) begin
                    state_d   = ST_IDLE;
                    loop_last = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            cf_q   <= 1'b0;
            zf_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            done_q <= 1'b0;
            if (state_q == ST_LOOP) begin
                acc_q  <= add_res;
                zf_q   <= (add_res == '0);
                cf_q   <= cf_q | sum_w[WIDTH];
                cnt_q  <= cnt_q - WIDTH'(1);
                done_q <= loop_last;
            end else if (accept) begin
                done_q <= 1'b1;
                case (op)
                    OP_LDA: begin
                        acc_q <= cmd_data;
                        cf_q  <= 1'b0;
                        zf_q  <= (cmd_data == '0);
                    end
                    OP_ADD: begin
                        acc_q <= add_res;
                        cf_q  <= sum_w[WIDTH];
                        zf_q  <= (add_res == '0);
                    end
                    OP_SUB: begin
                        acc_q <= sub_res;
                        cf_q  <= dif_w[WIDTH];
                        zf_q  <= (sub_res == '0);
                    end
                    OP_MAC: begin
                        // Count of zero completes like a NOP; otherwise done waits for the loop.
                        if (cmd_data != '0) begin
                            opnd_q <= rd_dat;
                            cnt_q  <= cmd_data;
                            cf_q   <= 1'b0;
                            done_q <= 1'b0;
                        end
                    end
                    OP_CLR: begin
                        acc_q <= '0;
                        cf_q  <= 1'b0;
                        zf_q  <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign acc_out = acc_q;
    assign cf      = cf_q;
    assign zf      = zf_q;
    assign done    = done_q;

endmodule
